// File: rtl/wb_bus_pkg.sv
// rtl/wb_bus_pkg.sv - shared state encoding and address-decode constants for wb_bus_router
package wb_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Bit positions measured down from the address MSB: RAM select is the MSB,
   // the slave index field starts immediately below it.
   localparam int RAM_BIT_OFS  = 1;
   localparam int IDX_MSB_OFS  = 2;

   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_bus_decode.sv
// rtl/wb_bus_decode.sv - combinational CPU address decode into RAM/slave target and forwarded address
module wb_bus_decode
   import wb_bus_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int SEL_BITS = 3,
   parameter int NSLAVE   = 2**SEL_BITS
) (
   input  logic [ADDR_W-1:0]   addr,
   output logic                is_ram,
   output logic [SEL_BITS-1:0] index,
   output logic                unmapped,
   output logic [ADDR_W-1:0]   fwd_addr
);

   localparam logic [SEL_BITS:0] NSLAVE_LIM = (SEL_BITS+1)'(NSLAVE);

   assign is_ram   = ~addr[ADDR_W-RAM_BIT_OFS];
   assign index    = addr[ADDR_W-IDX_MSB_OFS -: SEL_BITS];
   assign unmapped = ~is_ram & ({1'b0, index} >= NSLAVE_LIM);
   // Targets only see the offset inside their window.
   assign fwd_addr = {{(1+SEL_BITS){1'b0}}, addr[ADDR_W-2-SEL_BITS:0]};

endmodule

// File: rtl/wb_bus_router.sv
// rtl/wb_bus_router.sv - CPU to RAM/peripheral router with registered ack; optional watchdog via WB_BUS_ROUTER_TIMEOUT_EN
module wb_bus_router
   import wb_bus_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int SEL_BITS = 3,
   parameter int NSLAVE   = 2**SEL_BITS,
   parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        io_from_cpu_addr,
   input  logic [DATA_W-1:0]        io_from_cpu_dat2,
   input  logic                     io_from_cpu_sel,
   input  logic                     io_from_cpu_we,
   output logic [DATA_W-1:0]        io_from_cpu_dat4,
   output logic                     io_from_cpu_ack,
   output logic                     io_from_cpu_err,
   output logic [ADDR_W-1:0]        io_ram_slave_addr,
   output logic [DATA_W-1:0]        io_ram_slave_dat2,
   output logic                     io_ram_slave_sel,
   output logic                     io_ram_slave_we,
   input  logic [DATA_W-1:0]        io_ram_slave_dat4,
   input  logic                     io_ram_slave_ack,
   output logic [NSLAVE*ADDR_W-1:0] io_slaves_addr,
   output logic [NSLAVE*DATA_W-1:0] io_slaves_dat2,
   output logic [NSLAVE-1:0]        io_slaves_sel,
   output logic [NSLAVE-1:0]        io_slaves_we,
   input  logic [NSLAVE*DATA_W-1:0] io_slaves_dat4,
   input  logic [NSLAVE-1:0]        io_slaves_ack
);

   if (TIMEOUT < 1 || TIMEOUT > 65535 || NSLAVE > 2**SEL_BITS) begin : g_cfg_check
      $error("wb_bus_router: illegal TIMEOUT/NSLAVE parameterisation");
   end

   logic                dec_is_ram;
   logic [SEL_BITS-1:0] dec_index;
   logic                dec_unmapped;
   logic [ADDR_W-1:0]   dec_fwd;

   wb_bus_decode #(
      .ADDR_W   (ADDR_W),
      .SEL_BITS (SEL_BITS),
      .NSLAVE   (NSLAVE)
   ) u_decode (
      .addr     (io_from_cpu_addr),
      .is_ram   (dec_is_ram),
      .index    (dec_index),
      .unmapped (dec_unmapped),
      .fwd_addr (dec_fwd)
   );

   state_t              state;
   logic                tgt_ram;
   logic [SEL_BITS-1:0] tgt_idx;
   logic                req_we;
   logic [ADDR_W-1:0]   addr_q;
   logic                ram_sel_q;
   logic                ram_we_q;
   logic [NSLAVE-1:0]   slv_sel_q;
   logic [NSLAVE-1:0]   slv_we_q;
   logic                ack_q;
   logic                err_q;
   logic [DATA_W-1:0]   dat4_q;

   logic [DATA_W-1:0]   slv_rdata [NSLAVE];
   logic                tgt_ack;
   logic [DATA_W-1:0]   tgt_rdata;
   logic [NSLAVE-1:0]   dec_onehot;

   for (genvar i = 0; i < NSLAVE; i++) begin : g_unpack
      assign slv_rdata[i] = io_slaves_dat4[i*DATA_W +: DATA_W];
   end

   assign dec_onehot = NSLAVE'(1) << dec_index;

   // Only the latched target's ack/data matter; other slaves are ignored.
   always_comb begin
      tgt_ack   = 1'b0;
      tgt_rdata = '0;
      if (tgt_ram) begin
         tgt_ack   = io_ram_slave_ack;
         tgt_rdata = io_ram_slave_dat4;
      end else begin
         tgt_ack   = io_slaves_ack[tgt_idx];
         tgt_rdata = slv_rdata[tgt_idx];
      end
   end

`ifdef WB_BUS_ROUTER_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);
   logic [15:0] wd_cnt;
   logic [15:0] wd_cnt_next;
   assign wd_cnt_next = wd_cnt + 16'd1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         tgt_ram   <= 1'b0;
         tgt_idx   <= '0;
         req_we    <= 1'b0;
         addr_q    <= '0;
         ram_sel_q <= 1'b0;
         ram_we_q  <= 1'b0;
         slv_sel_q <= '0;
         slv_we_q  <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         dat4_q    <= '0;
`ifdef WB_BUS_ROUTER_TIMEOUT_EN
         wd_cnt    <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               ack_q <= 1'b0;
               err_q <= 1'b0;
               if (io_from_cpu_sel) begin
                  addr_q  <= dec_fwd;
                  tgt_ram <= dec_is_ram;
                  tgt_idx <= dec_index;
                  req_we  <= io_from_cpu_we;
`ifdef WB_BUS_ROUTER_TIMEOUT_EN
                  wd_cnt  <= '0;
`endif
                  if (dec_unmapped) begin
                     state <= ST_RESP;
                     ack_q <= 1'b1;
                     err_q <= 1'b1;
                  end else begin
                     state     <= ST_REQ;
                     ram_sel_q <= dec_is_ram;
                     ram_we_q  <= dec_is_ram & io_from_cpu_we;
                     slv_sel_q <= dec_is_ram ? '0 : dec_onehot;
                     slv_we_q  <= dec_is_ram ? '0 : (dec_onehot & {NSLAVE{io_from_cpu_we}});
                  end
               end
            end
            ST_REQ: begin
               if (tgt_ack) begin
                  dat4_q    <= req_we ? '0 : tgt_rdata;
                  ram_sel_q <= 1'b0;
                  ram_we_q  <= 1'b0;
                  slv_sel_q <= '0;
                  slv_we_q  <= '0;
                  ack_q     <= 1'b1;
                  err_q     <= 1'b0;
                  state     <= ST_RESP;
               end
`ifdef WB_BUS_ROUTER_TIMEOUT_EN
               else if (wd_cnt_next == TIMEOUT_LIM) begin
                  dat4_q    <= '0;
                  ram_sel_q <= 1'b0;
                  ram_we_q  <= 1'b0;
                  slv_sel_q <= '0;
                  slv_we_q  <= '0;
                  ack_q     <= 1'b1;
                  err_q     <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  wd_cnt <= wd_cnt_next;
               end
`endif
            end
            ST_RESP: begin
               ack_q <= 1'b0;
               err_q <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign io_from_cpu_dat4  = dat4_q;
   assign io_from_cpu_ack   = ack_q;
   assign io_from_cpu_err   = err_q;
   assign io_ram_slave_addr = addr_q;
   assign io_ram_slave_dat2 = io_from_cpu_dat2;
   assign io_ram_slave_sel  = ram_sel_q;
   assign io_ram_slave_we   = ram_we_q;
   assign io_slaves_addr    = {NSLAVE{addr_q}};
   assign io_slaves_dat2    = {NSLAVE{io_from_cpu_dat2}};
   assign io_slaves_sel     = slv_sel_q;
   assign io_slaves_we      = slv_we_q;

endmodule
